// File: rtl/apb_uart_tx.sv
// APB3 zero-wait slave with a small TX FIFO feeding an 8N1 serializer.
// Register map: 0x0 TXDATA, 0x4 STATUS, 0x8 BAUDDIV, 0xC CTRL.
module apb_uart_tx #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd433,
  parameter int unsigned CNT_W       = 3
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        txd,
  output logic        tx_busy,
  output logic        irq
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, empty;

  logic [15:0] baud_div;
  logic        ie;

  state_e      state, state_d;
  logic [15:0] bitlen, bitlen_d;
  logic [15:0] baud_cnt, baud_cnt_d;
  logic [2:0]  bit_idx, bit_idx_d;
  logic [7:0]  shreg, shreg_d;
  logic        bit_done, pop, txd_d;

  logic access, aligned, sel_tx, sel_st, sel_div, sel_ctrl, push;
  logic unused_bits;

  assign unused_bits = ^{PADDR[31:4], PWDATA[31:16]};

  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign bit_done = (baud_cnt == bitlen);

  // APB decode; every aligned offset in PADDR[3:0] maps to a register
  always_comb begin
    access   = PSEL & PENABLE;
    aligned  = (PADDR[1:0] == 2'b00);
    sel_tx   = aligned && (PADDR[3:2] == 2'd0);
    sel_st   = aligned && (PADDR[3:2] == 2'd1);
    sel_div  = aligned && (PADDR[3:2] == 2'd2);
    sel_ctrl = aligned && (PADDR[3:2] == 2'd3);
    push     = access & PWRITE & sel_tx & ~full;
    PREADY   = access;
    PSLVERR  = access & (~aligned | (PWRITE & (sel_st | (sel_tx & full))));
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      if (sel_st)   PRDATA = 32'({count, empty, full, tx_busy});
      if (sel_div)  PRDATA = {16'h0000, baud_div};
      if (sel_ctrl) PRDATA = {31'h0, ie};
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      baud_div <= DEFAULT_DIV;
      ie       <= 1'b0;
    end else if (access && PWRITE) begin
      if (sel_div)  baud_div <= PWDATA[15:0];
      if (sel_ctrl) ie       <= PWDATA[0];
    end
  end

  // FIFO storage is not reset; pointers and count define its contents
  always_ff @(posedge PCLK) begin
    if (push) mem[wr_ptr] <= PWDATA[7:0];
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Serializer state and datapath registers
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state    <= S_IDLE;
      bitlen   <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      txd      <= 1'b1;
      tx_busy  <= 1'b0;
      irq      <= 1'b0;
    end else begin
      state    <= state_d;
      bitlen   <= bitlen_d;
      baud_cnt <= baud_cnt_d;
      bit_idx  <= bit_idx_d;
      shreg    <= shreg_d;
      txd      <= txd_d;
      tx_busy  <= (state_d != S_IDLE);
      irq      <= ie & empty & ~tx_busy;
    end
  end

  always_comb begin
    state_d    = state;
    bitlen_d   = bitlen;
    baud_cnt_d = baud_cnt;
    bit_idx_d  = bit_idx;
    shreg_d    = shreg;
    case (state)
      S_IDLE: ;
      S_START: begin
        if (bit_done) begin
          state_d    = S_DATA;
          baud_cnt_d = '0;
          bit_idx_d  = '0;
        end else begin
          baud_cnt_d = baud_cnt + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          shreg_d    = {1'b0, shreg[7:1]};
          if (bit_idx == 3'd7) state_d   = S_STOP;
          else                 bit_idx_d = bit_idx + 3'd1;
        end else begin
          baud_cnt_d = baud_cnt + 16'd1;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          state_d    = S_IDLE;
          baud_cnt_d = '0;
        end else begin
          baud_cnt_d = baud_cnt + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A pop starts a new frame straight away, also back-to-back after STOP
    if (pop) begin
      state_d    = S_START;
      shreg_d    = mem[rd_ptr];
      bitlen_d   = baud_div;
      baud_cnt_d = '0;
    end
  end

  always_comb begin
    pop   = ~empty & ((state == S_IDLE) | ((state == S_STOP) & bit_done));
    txd_d = 1'b1;
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shreg_d[0];
      default: txd_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_apb_uart_tx.sv
// Randomized bench for apb_uart_tx: APB driver, txd frame receiver and
// a byte-queue reference model of what must appear on the line.
module tb_apb_uart_tx;

  localparam int unsigned DEPTH = 4;

  logic        PCLK, PRESETn, PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR, txd, tx_busy, irq;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  logic             rx_on    = 1'b0;
  int unsigned      rx_l     = 434;
  int unsigned      idle_run = 0;
  logic [7:0]       rx_bytes[$];
  int unsigned      rx_gaps[$];
  logic [7:0]       stim_q[$];

  apb_uart_tx #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd433), .CNT_W(3)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .txd(txd), .tx_busy(tx_busy), .irq(irq)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Both APB tasks are entered 1 time unit after a rising edge
  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [31:0] a, output logic [31:0] d, output logic err,
                        output logic rdy);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    d = PRDATA; err = PSLVERR; rdy = PREADY;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic set_div(input int unsigned d);
    logic err, rdy;
    logic [31:0] rd;
    apb_wr(32'h8, {16'hDEAD, 16'(d)}, err);
    check("div_wr_err", 32'(err), 32'd0);
    apb_rd(32'h8, rd, err, rdy);
    check("div_readback", rd, 32'(d));
    rx_l = d + 1;
  endtask

  task automatic wait_rx(input int unsigned n, input int unsigned budget);
    int unsigned k = 0;
    while (rx_bytes.size() < n && k < budget) begin
      @(posedge PCLK);
      k++;
    end
    #1;
    check("rx_frame_count", 32'(rx_bytes.size()), 32'(n));
  endtask

  // Bytes written from an idle, empty state: within the burst only the first
  // byte can leave the FIFO, so DEPTH+1 writes fit and the rest are rejected.
  task automatic burst(input int unsigned div);
    logic        err, rdy;
    logic [31:0] rd, exp_st;
    logic [7:0]  exp_q[$];
    int unsigned n, acc, cnt;
    n = stim_q.size();
    set_div(div);
    rx_bytes.delete();
    rx_gaps.delete();
    for (int i = 0; i < int'(n); i++) begin
      apb_wr(32'h0, {24'hABCDEF, stim_q[i]}, err);
      check("push_err", 32'(err), 32'(i >= int'(DEPTH + 1)));
      if (i < int'(DEPTH + 1)) exp_q.push_back(stim_q[i]);
    end
    acc = exp_q.size();
    if (2 * n <= 10 * (div + 1)) begin
      apb_rd(32'h4, rd, err, rdy);
      cnt    = acc - 1;
      exp_st = 32'd1 + ((cnt == DEPTH) ? 32'd2 : 32'd0) + ((cnt == 0) ? 32'd4 : 32'd0)
               + 32'(cnt * 8);
      check("status_in_burst", rd, exp_st);
    end
    wait_rx(acc, acc * 10 * (div + 1) + 100);
    for (int i = 0; i < int'(acc) && i < rx_bytes.size(); i++) begin
      check("rx_byte", 32'(rx_bytes[i]), 32'(exp_q[i]));
      if (i > 0) check("rx_gap", rx_gaps[i], 32'd0);
    end
    repeat (3) @(posedge PCLK);
    #1;
    apb_rd(32'h4, rd, err, rdy);
    check("status_drained", rd, 32'h4);
  endtask

  // Line receiver: samples each bit at its centre, knowing cycles per bit
  initial begin : rx_mon
    int unsigned l;
    logic [7:0]  b;
    forever begin
      @(negedge PCLK);
      if (rx_on && PRESETn && txd === 1'b0) begin
        l = rx_l;
        b = '0;
        repeat (l / 2) @(negedge PCLK);
        check("rx_start_bit", 32'(txd), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (l) @(negedge PCLK);
          b[i] = txd;
        end
        repeat (l) @(negedge PCLK);
        check("rx_stop_bit", 32'(txd), 32'd1);
        repeat (l - 1 - l / 2) @(negedge PCLK);
        rx_bytes.push_back(b);
        rx_gaps.push_back(idle_run);
        idle_run = 0;
      end else begin
        idle_run++;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic        err, rdy;
    logic [31:0] rd;
    logic [7:0]  byte_a5;
    logic        exp_bit, irq0;
    int          first_hi;
    int unsigned lows;

    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    PRESETn = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    PRESETn = 1'b1;
    rx_on   = 1'b1;
    @(posedge PCLK); #1;
    apb_rd(32'h4, rd, err, rdy);
    check("rst_status", rd, 32'h4);
    check("rst_status_err", {30'd0, err, rdy}, 32'h1);
    apb_rd(32'h8, rd, err, rdy);
    check("rst_div", rd, 32'd433);
    check("rst_div_err", {30'd0, err, rdy}, 32'h1);
    apb_rd(32'hC, rd, err, rdy);
    check("rst_ctrl", rd, 32'd0);
    check("rst_ctrl_err", {30'd0, err, rdy}, 32'h1);

    // Single byte, 4 cycles per bit, checked cycle by cycle
    set_div(3);
    byte_a5 = 8'hA5;
    apb_wr(32'h0, 32'hA5, err);
    check("single_push_err", 32'(err), 32'd0);
    @(negedge PCLK);
    check("single_pre_start", 32'(txd), 32'd1);
    for (int k = 0; k < 40; k++) begin
      @(negedge PCLK);
      if (k / 4 == 0)      exp_bit = 1'b0;
      else if (k / 4 == 9) exp_bit = 1'b1;
      else                 exp_bit = byte_a5[k / 4 - 1];
      check($sformatf("single_txd_c%0d", k), 32'(txd), 32'(exp_bit));
    end
    @(negedge PCLK);
    check("single_done_busy", 32'(tx_busy), 32'd0);
    @(posedge PCLK); #1;

    // Back-to-back frames at one cycle per bit
    stim_q = '{8'h55, 8'h0F};
    burst(0);

    // Overflow at a slow rate
    stim_q.delete();
    for (int i = 0; i < 6; i++) stim_q.push_back(8'($urandom));
    burst(100);

    // Error responses leave state untouched
    apb_rd(32'h6, rd, err, rdy);
    check("err_rd_unaligned", {err, rd[30:0]}, 32'h80000000);
    apb_wr(32'h4, 32'hFF, err);
    check("err_wr_status", 32'(err), 32'd1);
    apb_wr(32'h2, 32'h77, err);
    check("err_wr_unaligned", 32'(err), 32'd1);
    apb_rd(32'h4, rd, err, rdy);
    check("err_status_kept", rd, 32'h4);
    apb_rd(32'h8, rd, err, rdy);
    check("err_div_kept", rd, 32'd100);
    apb_rd(32'hC, rd, err, rdy);
    check("err_ctrl_kept", rd, 32'd0);
    rx_bytes.delete();
    repeat (20) @(posedge PCLK);
    #1;
    check("err_no_frame", 32'(rx_bytes.size()), 32'd0);

    // Randomized bursts
    for (int r = 0; r < 8; r++) begin
      stim_q.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) stim_q.push_back(8'($urandom));
      burst($urandom_range(0, 5));
    end

    // irq: registered, drops one cycle after a push, returns after STOP
    set_div(0);
    apb_wr(32'hC, 32'h1, err);
    @(negedge PCLK);
    check("irq_lag", 32'(irq), 32'd0);
    @(negedge PCLK);
    check("irq_idle_on", 32'(irq), 32'd1);
    @(posedge PCLK); #1;
    rx_bytes.delete();
    apb_wr(32'h0, 32'h3C, err);
    irq0     = 1'b0;
    first_hi = -1;
    for (int k = 0; k <= 40; k++) begin
      @(negedge PCLK);
      if (k == 0) irq0 = irq;
      else if (irq && first_hi < 0) first_hi = k;
    end
    check("irq_after_push", 32'(irq0), 32'd1);
    check("irq_rise_cycle", 32'(first_hi), 32'd12);
    @(posedge PCLK); #1;
    wait_rx(1, 50);
    if (rx_bytes.size() > 0) check("irq_rx_byte", 32'(rx_bytes[0]), 32'h3C);

    // Reset in the middle of a frame with a second byte still queued
    set_div(3);
    rx_on = 1'b0;
    apb_wr(32'h0, 32'h00, err);
    apb_wr(32'h0, 32'h00, err);
    repeat (8) @(posedge PCLK);
    #1;
    check("mid_pre_txd", {31'd0, txd}, 32'd0);
    check("mid_pre_busy", 32'(tx_busy), 32'd1);
    PRESETn = 1'b0;
    @(posedge PCLK); #1;
    check("mid_rst_txd", 32'(txd), 32'd1);
    check("mid_rst_busy", 32'(tx_busy), 32'd0);
    check("mid_rst_irq", 32'(irq), 32'd0);
    PRESETn = 1'b1;
    apb_rd(32'h4, rd, err, rdy);
    check("mid_rst_status", rd, 32'h4);
    apb_rd(32'hC, rd, err, rdy);
    check("mid_rst_ctrl", rd, 32'd0);
    apb_rd(32'h8, rd, err, rdy);
    check("mid_rst_div", rd, 32'd433);
    lows = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge PCLK);
      if (txd !== 1'b1) lows++;
    end
    check("mid_rst_line_idle", lows, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
